alarm_key_entry: RTL and testbench

ALARM_KEY_ENTRY -- requirements
Module: alarm_key_entry

---
 rtl/alarm_key_entry.sv | 170 +++++++++++++++++
 tb/tb_alarm_key_entry.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/alarm_key_entry.sv
// Alarm-clock keypad entry: collects four BCD digits and commits them as alarm or current time.
// Optional commit-time range check enabled by defining ALARM_KEY_RANGE_CHK_EN.
module alarm_key_entry #(
  parameter int unsigned TIMEOUT_SEC = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       one_second,
  input  logic       key_valid,
  input  logic [3:0] key,
  output logic [3:0] new_alarm_time_ms_hr,
  output logic [3:0] new_alarm_time_ls_hr,
  output logic [3:0] new_alarm_time_ms_min,
  output logic [3:0] new_alarm_time_ls_min,
  output logic       load_new_a,
  output logic       load_new_c,
  output logic       show_new_time,
  output logic       entry_error
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ENTRY  = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  localparam logic [3:0] K_ALARM = 4'hA;
  localparam logic [3:0] K_TIME  = 4'hB;
  localparam logic [3:0] K_CLEAR = 4'hF;

  localparam logic [3:0] TMO_LIMIT = 4'(TIMEOUT_SEC);

  logic [1:0]  state_q, state_d;
  logic [15:0] digits_q, digits_d;
  logic [2:0]  count_q, count_d;
  logic [3:0]  tmo_q, tmo_d;
  logic        load_a_q, load_a_d;
  logic        load_c_q, load_c_d;
  logic        show_q, show_d;
  logic        key_digit, key_alarm, key_time, key_clear;
  logic        commit_reject;

  assign key_digit = key_valid && (key <= 4'd9);
  assign key_alarm = key_valid && (key == K_ALARM);
  assign key_time  = key_valid && (key == K_TIME);
  assign key_clear = key_valid && (key == K_CLEAR);

`ifdef ALARM_KEY_RANGE_CHK_EN
  logic err_q, err_d;

  // Hours 00..23, minutes 00..59; digits are always 0..9 so ls_min needs no check.
  assign commit_reject = !(((digits_q[15:12] < 4'd2) ||
                            ((digits_q[15:12] == 4'd2) && (digits_q[11:8] <= 4'd3))) &&
                           (digits_q[7:4] <= 4'd5));
  assign entry_error   = err_q;
`else
  assign commit_reject = 1'b0;
  assign entry_error   = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    count_d  = count_q;
    tmo_d    = tmo_q;
    load_a_d = 1'b0;
    load_c_d = 1'b0;
`ifdef ALARM_KEY_RANGE_CHK_EN
    err_d    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        tmo_d = '0;
        if (key_digit) begin
          state_d  = S_ENTRY;
          digits_d = {12'h000, key};
          count_d  = 3'd1;
        end
      end
      S_ENTRY: begin
        if (key_digit) begin
          digits_d = {digits_q[11:0], key};
          count_d  = (count_q == 3'd4) ? 3'd4 : count_q + 3'd1;
          tmo_d    = '0;
        end else if (key_alarm || key_time) begin
          tmo_d = '0;
          if (count_q == 3'd4) begin
            state_d = S_COMMIT;
            if (commit_reject) begin
`ifdef ALARM_KEY_RANGE_CHK_EN
              err_d = 1'b1;
`endif
            end else begin
              load_a_d = key_alarm;
              load_c_d = key_time;
            end
          end else begin
            state_d  = S_IDLE;
            digits_d = '0;
            count_d  = '0;
          end
        end else if (key_clear) begin
          state_d  = S_IDLE;
          digits_d = '0;
          count_d  = '0;
          tmo_d    = '0;
        end else if (one_second) begin
          // Ignored key codes fall through here, so they do not restart the timeout.
          if (tmo_q + 4'd1 == TMO_LIMIT) begin
            state_d  = S_IDLE;
            digits_d = '0;
            count_d  = '0;
            tmo_d    = '0;
          end else begin
            tmo_d = tmo_q + 4'd1;
          end
        end
      end
      S_COMMIT: begin
        state_d = S_IDLE;
        count_d = '0;
        tmo_d   = '0;
`ifdef ALARM_KEY_RANGE_CHK_EN
        if (err_q) digits_d = '0;
`endif
      end
      default: begin
        state_d  = S_IDLE;
        digits_d = '0;
        count_d  = '0;
        tmo_d    = '0;
      end
    endcase
    show_d = (state_d == S_ENTRY);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      digits_q <= '0;
      count_q  <= '0;
      tmo_q    <= '0;
      load_a_q <= 1'b0;
      load_c_q <= 1'b0;
      show_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      count_q  <= count_d;
      tmo_q    <= tmo_d;
      load_a_q <= load_a_d;
      load_c_q <= load_c_d;
      show_q   <= show_d;
    end
  end

`ifdef ALARM_KEY_RANGE_CHK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_q <= 1'b0;
    else          err_q <= err_d;
  end
`endif

  assign new_alarm_time_ms_hr  = digits_q[15:12];
  assign new_alarm_time_ls_hr  = digits_q[11:8];
  assign new_alarm_time_ms_min = digits_q[7:4];
  assign new_alarm_time_ls_min = digits_q[3:0];
  assign load_new_a            = load_a_q;
  assign load_new_c            = load_c_q;
  assign show_new_time         = show_q;

endmodule

// File: tb/tb_alarm_key_entry.sv
// Scoreboard bench for alarm_key_entry: commit results queued at key time, popped on load/error pulses.
`timescale 1ns/1ps
module tb_alarm_key_entry;

  localparam int unsigned TO = 10;
`ifdef ALARM_KEY_RANGE_CHK_EN
  localparam bit RANGE_CHK = 1'b1;
`else
  localparam bit RANGE_CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       one_second = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key = 4'h0;
  logic [3:0] ms_hr, ls_hr, ms_min, ls_min;
  logic       load_new_a, load_new_c, show_new_time, entry_error;
  logic [15:0] dut_dig;

  alarm_key_entry #(.TIMEOUT_SEC(TO)) u_dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .one_second            (one_second),
    .key_valid             (key_valid),
    .key                   (key),
    .new_alarm_time_ms_hr  (ms_hr),
    .new_alarm_time_ls_hr  (ls_hr),
    .new_alarm_time_ms_min (ms_min),
    .new_alarm_time_ls_min (ls_min),
    .load_new_a            (load_new_a),
    .load_new_c            (load_new_c),
    .show_new_time         (show_new_time),
    .entry_error           (entry_error)
  );

  assign dut_dig = {ms_hr, ls_hr, ms_min, ls_min};

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  kind;   // {load_new_a, load_new_c, entry_error}
    logic [15:0] dig;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  bit          m_entry = 1'b0;
  logic [15:0] m_dig = '0;
  int          m_cnt = 0;
  int          m_tmo = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor: every pulse must match the oldest expected commit.
  always begin
    @(posedge clk);
    cyc++;
    #1;
    if (reset_n && (load_new_a || load_new_c || entry_error)) begin
      check_eq("excl", {31'd0, load_new_a && load_new_c}, 32'd0);
      if (sb.size() == 0) begin
        check_eq("unexp_pulse", {29'd0, load_new_a, load_new_c, entry_error}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check_eq("kind", {29'd0, load_new_a, load_new_c, entry_error}, {29'd0, mon_e.kind});
        check_eq("commit_dig", {16'd0, dut_dig}, {16'd0, mon_e.dig});
        check_eq("latency", cyc, mon_e.cyc);
      end
    end
  end

  task automatic model_clear();
    m_entry = 1'b0;
    m_dig   = '0;
    m_cnt   = 0;
    m_tmo   = 0;
  endtask

  // One input cycle plus one idle cycle, then compare display state against the model.
  task automatic step(input logic [3:0] k, input bit kv, input bit tick);
    exp_t e;
    int hours, mins;
    bit bad;
    @(negedge clk);
    key_valid  = kv;
    key        = k;
    one_second = tick;
    if (kv && k <= 4'd9) begin
      if (!m_entry) begin
        m_entry = 1'b1;
        m_dig   = {12'h000, k};
        m_cnt   = 1;
      end else begin
        m_dig = {m_dig[11:0], k};
        m_cnt = (m_cnt < 4) ? m_cnt + 1 : 4;
      end
      m_tmo = 0;
    end else if (kv && m_entry && (k == 4'hA || k == 4'hB)) begin
      if (m_cnt == 4) begin
        hours  = m_dig[15:12] * 10 + m_dig[11:8];
        mins   = m_dig[7:4] * 10 + m_dig[3:0];
        bad    = RANGE_CHK && (hours > 23 || mins > 59);
        e.kind = bad ? 3'b001 : ((k == 4'hA) ? 3'b100 : 3'b010);
        e.dig  = m_dig;
        e.cyc  = cyc + 1;
        sb.push_back(e);
        m_entry = 1'b0;
        m_cnt   = 0;
        m_tmo   = 0;
        if (bad) m_dig = '0;
      end else begin
        model_clear();
      end
    end else if (kv && m_entry && k == 4'hF) begin
      model_clear();
    end else if (tick && m_entry) begin
      m_tmo++;
      if (m_tmo == TO) model_clear();
    end
    @(negedge clk);
    key_valid  = 1'b0;
    one_second = 1'b0;
    @(negedge clk);
    check_eq("show", {31'd0, show_new_time}, {31'd0, m_entry});
    check_eq("digits", {16'd0, dut_dig}, {16'd0, m_dig});
  endtask

  task automatic keys(input logic [3:0] ks[$]);
    foreach (ks[i]) step(ks[i], 1'b1, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq(tag, {12'd0, dut_dig, load_new_a, load_new_c, show_new_time, entry_error}, 32'd0);
  endtask

  initial begin
    #12;
    check_all_zero("reset_outs");
    @(negedge clk);
    reset_n = 1'b1;

    // ALARM commit, then held digits and ignored ALARM in IDLE.
    keys('{4'd1, 4'd2, 4'd3, 4'd4, 4'hA});
    step(4'hA, 1'b1, 1'b0);
    // Leading digit discarded, TIME commit.
    keys('{4'd9, 4'd0, 4'd7, 4'd3, 4'd0, 4'hB});
    // Aborted entries.
    keys('{4'd1, 4'd2, 4'hA});
    keys('{4'd1, 4'hF});
    // Unrecognised key ignored inside an entry.
    keys('{4'd1, 4'hE, 4'd2, 4'd3, 4'd4, 4'hB});
    // Range boundary: 25:00 rejected only with the check, 19:59 always valid.
    keys('{4'd2, 4'd5, 4'd0, 4'd0, 4'hA});
    keys('{4'd1, 4'd9, 4'd5, 4'd9, 4'hB});
    keys('{4'd2, 4'd3, 4'd6, 4'd0, 4'hA});

    // Timeout after TO ticks.
    step(4'd5, 1'b1, 1'b0);
    for (int i = 0; i < int'(TO); i++) step(4'h0, 1'b0, 1'b1);
    // Key coincident with tick TO-1 restarts the counter.
    step(4'd5, 1'b1, 1'b0);
    for (int i = 0; i < int'(TO) - 2; i++) step(4'h0, 1'b0, 1'b1);
    step(4'd6, 1'b1, 1'b1);
    for (int i = 0; i < int'(TO); i++) step(4'h0, 1'b0, 1'b1);

    // Reset landing in the COMMIT cycle must swallow the load pulse.
    keys('{4'd1, 4'd2, 4'd3, 4'd4});
    @(negedge clk);
    key_valid = 1'b1;
    key       = 4'hA;
    @(posedge clk);
    #0.5;
    reset_n   = 1'b0;
    key_valid = 1'b0;
    #1;
    check_all_zero("reset_in_commit");
    model_clear();
    @(negedge clk);
    check_all_zero("reset_held");
    reset_n = 1'b1;
    step(4'hA, 1'b1, 1'b0);
    keys('{4'd0, 4'd8, 4'd4, 4'd5, 4'hB});

    repeat (4) @(negedge clk);
    check_eq("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
